input_fifo_port: RTL and testbench
==================================

// Module: input_fifo_port
// PURPOSE
//  Per-direction input buffer of a router: accepts 64-bit packets from the neighbouring
//  router (or local PE) link and presents them first-word-fall-through to the directional
//  routing unit (routing_dir_N/S/E/W), which pops via read_en/empty. Sits directly upstream
//  of the routing unit; its full output is the backpressure seen by the upstream arbiter.
// PARAMETERS
//  DATA_W   64  packet width (bits [58:53] carry dir_x, dir_y, hop_x, hop_y; untouched here)
//  DEPTH    4   number of packet slots; power of two, >= 2
//  PTR_W    2   log2(DEPTH)
// PORTS
//  clk        in   1        single clock; all state updates on posedge
//  reset      in   1        synchronous, active-low (reset==0 at posedge clears state)
//  in_valid   in   1        upstream presents in_packet this cycle
//  in_packet  in   DATA_W   packet from upstream link
//  full       out  1        no free slot; upstream must not push (push while full is dropped)
//  read_en    in   1        pop request from routing unit
//  out_packet out  DATA_W   head packet, valid whenever empty==0
//  empty      out  1        no stored packet
//  count      out  PTR_W+1  stored packets, 0..DEPTH
//  ovf_err    out  1        sticky: push attempted while full
//  unf_err    out  1        sticky: pop attempted while empty
// BEHAVIOUR
//  - Storage: DEPTH x DATA_W register array; wr_ptr/rd_ptr are PTR_W+1 bits (wrap bit).
//  - empty = (wr_ptr == rd_ptr); full = (ptr low bits equal && wrap bits differ);
//    count = wr_ptr - rd_ptr (mod 2^(PTR_W+1)). All three derive from registered pointers only.
//  - push = in_valid && !full; pop = read_en && !empty; both evaluated on current-cycle state.
//  - push: mem[wr_ptr[PTR_W-1:0]] <= in_packet; wr_ptr <= wr_ptr+1 at posedge.
//  - pop: rd_ptr <= rd_ptr+1 at posedge. Routing unit captures out_packet at the same edge,
//    so out_packet is combinational: mem[rd_ptr[PTR_W-1:0]] when !empty, else all zeros.
//  - Latency: packet pushed at edge k is visible on out_packet / empty==0 after edge k
//    (earliest pop at edge k+1). No bypass from in_packet to out_packet when empty.
//  - Simultaneous push+pop, non-empty and non-full: both happen, count unchanged.
//  - Full + in_valid + read_en: pop happens, push dropped (full is pre-edge state), ovf_err set.
//  - Empty + in_valid + read_en: push happens, pop ignored, unf_err set.
//  - Pointer wrap: low bits roll DEPTH-1 -> 0, wrap bit toggles; order strictly FIFO.
//  - Packet contents never modified; hop/dir fields pass through bit-exact.
//  - Errors sticky until reset; they never block operation.
//  - Reset (reset==0 at posedge, any time incl. mid-traffic): wr_ptr=rd_ptr=0, ovf_err=0,
//    unf_err=0 -> empty=1, full=0, count=0, out_packet=0. Stored data discarded (mem need
//    not be cleared). Inputs ignored during reset cycle; normal operation from next edge.
// TESTING
//  1 Reset held 2 cycles with in_valid=1 -> empty=1, full=0, count=0, out_packet=0, errs=0.
//  2 Push 64'h0000_0000_0000_0001..4 on 4 cycles, read_en=0 -> count 1,2,3,4; full=1 after
//    4th edge; out_packet=...0001; 5th push (...0005) dropped, ovf_err=1, count stays 4.
//  3 From full, read_en=1 4 cycles -> out_packet 0001,0002,0003,0004 in order; empty=1
//    after 4th edge; 5th read_en with empty=1 -> unf_err=1, count stays 0.
//  4 Continuous push+pop 10 cycles with 1 preloaded entry -> count stays 1, ptrs wrap
//    twice, out_packet sequence matches push order exactly (scoreboard).
//  5 Packet 64'h0680_0000_0000_00AA (dir_x=1, hop_x=1, hop_y=0) pushed then popped ->
//    out_packet bit-identical; routing_dir_W model sees hop fields unmodified.
//  6 Reset pulsed while count=3 -> next cycle empty=1, count=0, errs=0; new push of
//    64'hBEEF appears as head (no stale data).

Source files
------------

// File: rtl/input_fifo_port.sv
// First-word-fall-through packet buffer feeding one directional routing unit.
// full is the backpressure seen upstream; ovf/unf flags record protocol misuse.
module input_fifo_port #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_packet,
  output logic              full,
  input  logic              read_en,
  output logic [DATA_W-1:0] out_packet,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic              ovf_err,
  output logic              unf_err
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              push;
  logic              pop;

  // The extra wrap bit separates "all slots used" from "no slots used"
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) &&
                 (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign count = wr_ptr - rd_ptr;

  assign push = in_valid && !full;
  assign pop  = read_en && !empty;

  assign out_packet = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (in_valid && full)
        ovf_err <= 1'b1;
      if (read_en && empty)
        unf_err <= 1'b1;
    end
  end

  // Storage carries no reset; stale slots are hidden behind the pointers
  always_ff @(posedge clk) begin
    if (reset && push)
      mem[wr_ptr[PTR_W-1:0]] <= in_packet;
  end

endmodule

// File: tb/tb_input_fifo_port.sv
// Self-checking bench for input_fifo_port: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_input_fifo_port;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_packet;
  logic              full;
  logic              read_en;
  logic [DATA_W-1:0] out_packet;
  logic              empty;
  logic [PTR_W:0]    count;
  logic              ovf_err;
  logic              unf_err;

  int checks;
  int failures;

  logic [DATA_W-1:0] model_q [$];
  logic              model_ovf;
  logic              model_unf;

  input_fifo_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_packet  (in_packet),
    .full       (full),
    .read_en    (read_en),
    .out_packet (out_packet),
    .empty      (empty),
    .count      (count),
    .ovf_err    (ovf_err),
    .unf_err    (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every output against the model's view of the buffer
  task automatic checkAll(input string tag);
    int sz;
    sz = model_q.size();
    checkOutput({tag, ".count"}, 64'(count), 64'(sz));
    checkOutput({tag, ".empty"}, 64'(empty), 64'(sz == 0));
    checkOutput({tag, ".full"}, 64'(full), 64'(sz == DEPTH));
    checkOutput({tag, ".out_packet"}, out_packet, (sz > 0) ? model_q[0] : 64'd0);
    checkOutput({tag, ".ovf_err"}, 64'(ovf_err), 64'(model_ovf));
    checkOutput({tag, ".unf_err"}, 64'(unf_err), 64'(model_unf));
  endtask

  // One clock of traffic: drive inputs, advance model with pre-edge state, check after edge
  task automatic applyStimulus(input logic rst_n, input logic v, input logic [63:0] pkt,
                               input logic rd, input string tag);
    bit do_push;
    bit do_pop;
    reset     = rst_n;
    in_valid  = v;
    in_packet = pkt;
    read_en   = rd;
    @(posedge clk);
    if (!rst_n) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else begin
      do_push = v && (model_q.size() < DEPTH);
      do_pop  = rd && (model_q.size() > 0);
      if (v && model_q.size() == DEPTH) model_ovf = 1'b1;
      if (rd && model_q.size() == 0) model_unf = 1'b1;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(pkt);
    end
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [63:0] pkt_a;
    logic [63:0] hop_expected;
    logic [63:0] head_seen;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_packet = '0;
    read_en   = 1'b0;
    checks    = 0;
    failures  = 0;
    model_ovf = 1'b0;
    model_unf = 1'b0;

    $display("[TB] reset with in_valid asserted");
    applyStimulus(1'b0, 1'b1, 64'hDEAD, 1'b0, "rst0");
    applyStimulus(1'b0, 1'b1, 64'hDEAD, 1'b0, "rst1");

    $display("[TB] fill to full and overflow");
    for (int i = 1; i <= 5; i++)
      applyStimulus(1'b1, 1'b1, 64'(i), 1'b0, $sformatf("fill%0d", i));
    checkOutput("fill.count_const", 64'(count), 64'd4);

    $display("[TB] drain to empty and underflow");
    for (int i = 1; i <= 5; i++) begin
      head_seen = out_packet;
      applyStimulus(1'b1, 1'b0, '0, 1'b1, $sformatf("drain%0d", i));
      if (i <= 4) checkOutput($sformatf("drain%0d.order", i), head_seen, 64'(i));
    end

    $display("[TB] streaming push+pop with one preloaded entry");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, "rst_stream");
    applyStimulus(1'b1, 1'b1, 64'h100, 1'b0, "preload");
    for (int i = 1; i <= 10; i++)
      applyStimulus(1'b1, 1'b1, 64'h100 + 64'(i), 1'b1, $sformatf("stream%0d", i));

    $display("[TB] hop/dir field pass-through");
    applyStimulus(1'b0, 1'b0, '0, 1'b0, "rst_hop");
    pkt_a = 64'h0680_0000_0000_00AA;
    hop_expected = 64'(pkt_a[58:53]);
    applyStimulus(1'b1, 1'b1, pkt_a, 1'b0, "hop_push");
    checkOutput("hop.fields", 64'(out_packet[58:53]), hop_expected);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, "hop_pop");

    $display("[TB] reset mid-traffic");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 64'hC0 + 64'(i), 1'b0, $sformatf("pre_rst%0d", i));
    applyStimulus(1'b1, 1'b0, '0, 1'b1, "unf_probe");
    applyStimulus(1'b0, 1'b1, 64'h1234, 1'b1, "mid_rst");
    applyStimulus(1'b1, 1'b1, 64'hBEEF, 1'b0, "post_rst");
    checkOutput("post_rst.head", out_packet, 64'hBEEF);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [63:0] rp;
      rp = {$urandom, $urandom};
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), rp,
                    ($urandom_range(0, 2) != 0), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
